// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, next-PC selection and fault/halt detection for the fetch stage
module pc_fetch_unit #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Stall,
  input  logic                   Redirect_Valid,
  input  logic [PC_WIDTH-1:0]    Redirect_Target,
  input  logic [INSTR_WIDTH-1:0] Instr_In,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_Plus4,
  output logic [INSTR_WIDTH-1:0] Instr_Out,
  output logic                   Instr_Valid,
  output logic                   Halted,
  output logic                   Fetch_Fault,
  output logic [PC_WIDTH-1:0]    Fault_PC,
  output logic [31:0]            Retired_Count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
  localparam logic [PC_WIDTH-1:0] LIMIT = PC_WIDTH'(4 * IMEM_DEPTH);
  localparam logic [INSTR_WIDTH-1:0] EBREAK = INSTR_WIDTH'(32'h0010_0073);
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);
  state_t state;
  logic bad_target;
  assign PC_Plus4 = PC + PC_WIDTH'(4);
  assign bad_target = (Redirect_Target[1:0] != 2'b00) || (Redirect_Target >= LIMIT);
  assign Instr_Valid = (state == RUN);
  assign Instr_Out = (state == RUN) ? Instr_In : NOP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      PC <= RESET_VECTOR;
      Retired_Count <= '0;
      Fault_PC <= '0;
      Halted <= 1'b0;
      Fetch_Fault <= 1'b0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (state == RUN && !Stall) begin
      if (Instr_In == EBREAK) begin
        state <= HALT;
        Halted <= 1'b1;
        Retired_Count <= Retired_Count + 32'd1;
      end else if (Redirect_Valid && bad_target) begin
        state <= FAULT;
        Fetch_Fault <= 1'b1;
        Fault_PC <= Redirect_Target;
      end else if (Redirect_Valid) begin
        PC <= Redirect_Target;
        Retired_Count <= Retired_Count + 32'd1;
      end else if (PC_Plus4 >= LIMIT) begin
        // the last ROM word retires, but PC stays inside the legal range
        state <= FAULT;
        Fetch_Fault <= 1'b1;
        Fault_PC <= PC_Plus4;
        Retired_Count <= Retired_Count + 32'd1;
      end else begin
        PC <= PC_Plus4;
        Retired_Count <= Retired_Count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random checks of pc_fetch_unit against a rule-level model
module tb_pc_fetch_unit;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, stall, rvalid;
  logic [31:0] rtgt, instr_in, pc, pc_plus4, instr_out, fault_pc, retired;
  logic instr_valid, halted, fetch_fault;
  logic [31:0] rom [256];
  int errors = 0;
  int checks = 0;
  int m_st;
  logic [31:0] m_pc, m_cnt, m_fpc;

  always #5 clk = ~clk;
  assign instr_in = (pc < 32'd1024) ? rom[pc[9:2]] : 32'h0;

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .Stall(stall), .Redirect_Valid(rvalid),
    .Redirect_Target(rtgt), .Instr_In(instr_in), .PC(pc), .PC_Plus4(pc_plus4),
    .Instr_Out(instr_out), .Instr_Valid(instr_valid), .Halted(halted),
    .Fetch_Fault(fetch_fault), .Fault_PC(fault_pc), .Retired_Count(retired)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model states: 0 boot, 1 run, 2 halted, 3 faulted
  task automatic tick(input logic r, input logic s, input logic rv, input logic [31:0] t);
    logic [31:0] w;
    rst = r; stall = s; rvalid = rv; rtgt = t;
    @(posedge clk);
    w = (m_pc < 32'd1024) ? rom[m_pc[9:2]] : 32'h0;
    if (r) begin
      m_st = 0; m_pc = 0; m_cnt = 0; m_fpc = 0;
    end else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && !s) begin
      if (w == EBREAK) begin m_st = 2; m_cnt++; end
      else if (rv && (t % 4 != 0 || t >= 1024)) begin m_st = 3; m_fpc = t; end
      else if (rv) begin m_pc = t; m_cnt++; end
      else begin
        m_cnt++;
        if (m_pc + 4 >= 1024) begin m_st = 3; m_fpc = m_pc + 4; end
        else m_pc = m_pc + 4;
      end
    end
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("pc_align", {30'd0, pc[1:0]}, 32'd0);
    chk("pc_plus4", pc_plus4, m_pc + 4);
    chk("valid", {31'd0, instr_valid}, {31'd0, m_st == 1});
    chk("halted", {31'd0, halted}, {31'd0, m_st == 2});
    chk("fault", {31'd0, fetch_fault}, {31'd0, m_st == 3});
    chk("fault_pc", fault_pc, m_fpc);
    chk("retired", retired, m_cnt);
    if (m_st == 1) chk("instr_run", instr_out, rom[m_pc[9:2]]);
    if (m_st >= 2) chk("instr_nop", instr_out, NOP);
  endtask

  task automatic do_reset();
    tick(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
    tick(1, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] t;
    int p;
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if (rom[i] == EBREAK) rom[i] = NOP;
    end
    m_st = 0; m_pc = 0; m_cnt = 0; m_fpc = 0;
    // reset and boot
    do_reset();
    chk("t1_pc", pc, 32'd0);
    chk("t1_boot_valid", {31'd0, instr_valid}, 32'd0);
    tick(0, 0, 0, 0);
    chk("t1_run_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_run_pc", pc, 32'd0);
    // sequential fetch
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    chk("t2_pc", pc, 32'd16);
    chk("t2_count", retired, 32'd4);
    // redirect held off by stall, then taken
    tick(0, 1, 1, 32'h40);
    chk("t3_stall_pc", pc, 32'd16);
    tick(0, 0, 1, 32'h40);
    chk("t3_redir_pc", pc, 32'h40);
    // misaligned redirect
    tick(0, 0, 1, 32'h42);
    chk("t4_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t4_fault_pc", fault_pc, 32'h42);
    for (int i = 0; i < 3; i++) tick(0, $urandom_range(0, 1), 1, 32'h80);
    chk("t4_pc_held", pc, 32'h40);
    chk("t4_nop", instr_out, NOP);
    // run off the end of the ROM
    do_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 32'h3FC);
    chk("t5_pc", pc, 32'h3FC);
    tick(0, 0, 0, 0);
    chk("t5_fault", {31'd0, fetch_fault}, 32'd1);
    chk("t5_fault_pc", fault_pc, 32'h400);
    // random traffic, including resets with stall/redirect pending
    for (int n = 0; n < 600; n++) begin
      p = $urandom_range(0, 99);
      t = (p < 5) ? ({$urandom_range(0, 255), 2'b00} | 32'($urandom_range(1, 3))) :
          (p < 8) ? 32'd1024 + 32'(4 * $urandom_range(0, 200)) :
          (p < 20) ? 32'(4 * $urandom_range(245, 255)) : 32'(4 * $urandom_range(0, 255));
      if (m_st >= 2 || $urandom_range(0, 99) < 2) tick(1, $urandom_range(0, 1), $urandom_range(0, 1), t);
      else tick(0, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20, t);
    end
    // EBREAK at word 3
    rom[3] = EBREAK;
    do_reset();
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0);
    chk("t6_halted", {31'd0, halted}, 32'd1);
    chk("t6_count", retired, 32'd4);
    chk("t6_pc", pc, 32'hC);
    tick(0, 0, 1, 32'h20);
    chk("t6_pc_held", pc, 32'hC);
    tick(1, 1, 1, 32'h20);
    chk("t6_rst_halted", {31'd0, halted}, 32'd0);
    chk("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_rst_count", retired, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
